// File: rtl/icache_ram_responder_pkg.sv
// Shared definitions for the icache refill-port RAM responder.
//   state_e      : FSM state encoding (IDLE / WAIT / RESP)
//   MEM_BASE_DEF : default byte address of array word 0
//   LFSR_SEED / LFSR_TAPS / lfsr_next : random-latency generator
//     (used only when ICACHE_RAM_RESP_RAND_LAT_EN is defined)
package icache_ram_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;

  // Wide enough for RD_LAT-1 (max 14) plus 7 random extra cycles.
  localparam int CNT_W = 5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (maximal length).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/icache_ram_array.sv
// 64-bit x 2^DEPTH_LOG2 synchronous word array.
//   clk          : clock
//   we/waddr/wdata : full-word write, commits on the clock edge
//   re/raddr     : read strobe and word index; rdata registered on the edge
//   rdata        : read data, holds its value while re is low
// A write and a read to the same word on the same edge return the new
// (write) data.
module icache_ram_array #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [63:0]           wdata,
  input  logic                  re,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [63:0]           rdata
);

  logic [63:0] mem [1<<DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
  end

endmodule

// File: rtl/icache_ram_responder.sv
// Memory-side responder for the icache refill port.
// Accepts one read request at a time, waits a configurable latency, then
// returns masked 64-bit data with a single-cycle ready pulse.
//   clk, rst                      : clock, synchronous active-high reset
//   ram_raddr_icache_i            : request byte address (bits [2:0] ignored)
//   ram_raddr_valid_icache_i      : request valid; dropping it in WAIT aborts
//   ram_rmask_icache_i            : byte-lane read mask
//   ram_rdata_ready_icache_o      : one-cycle data-valid pulse
//   ram_rdata_icache_o            : masked read data (zero outside the pulse)
//   resp_err_o                    : out-of-range flag, pulses with ready
//   preload_we_i/waddr_i/wdata_i  : boot/bench word write into the array
// Optional: define ICACHE_RAM_RESP_RAND_LAT_EN to add 0..7 pseudo-random
// extra wait cycles per request (latency RD_LAT..RD_LAT+7).
module icache_ram_responder
  import icache_ram_responder_pkg::*;
#(
  parameter logic [31:0] MEM_BASE   = MEM_BASE_DEF,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          RD_LAT     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ram_raddr_icache_i,
  input  logic        ram_raddr_valid_icache_i,
  input  logic [7:0]  ram_rmask_icache_i,
  output logic        ram_rdata_ready_icache_o,
  output logic [63:0] ram_rdata_icache_o,
  output logic        resp_err_o,
  input  logic        preload_we_i,
  input  logic [31:0] preload_waddr_i,
  input  logic [63:0] preload_wdata_i
);

  localparam logic [31:0] SPAN = 32'd8 << DEPTH_LOG2;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lat_load;
  logic [2:0]       lat_extra;
  logic [31:0]      addr_q;
  logic [7:0]       mask_q, omask_q;
  logic             err_q;
  logic             req_take, go_resp;

  logic [31:0] rd_addr, rd_off, wr_off;
  logic [7:0]  rd_mask;
  logic        rd_in_range, wr_in_range;
  logic [63:0] arr_rdata;

  // With RD_LAT = 1 the array is read on the acceptance edge, so in IDLE the
  // read side looks straight at the request inputs instead of the latches.
  assign rd_addr     = (state_q == ST_IDLE) ? ram_raddr_icache_i : addr_q;
  assign rd_mask     = (state_q == ST_IDLE) ? ram_rmask_icache_i : mask_q;
  assign rd_off      = rd_addr - MEM_BASE;
  assign rd_in_range = rd_off < SPAN;

  assign wr_off      = preload_waddr_i - MEM_BASE;
  assign wr_in_range = wr_off < SPAN;

  assign req_take = (state_q == ST_IDLE) && ram_raddr_valid_icache_i;
  assign lat_load = CNT_W'(RD_LAT - 1) + CNT_W'(lat_extra);

`ifdef ICACHE_RAM_RESP_RAND_LAT_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (rst)           lfsr_q <= LFSR_SEED;
    else if (req_take) lfsr_q <= lfsr_next(lfsr_q);
  end

  assign lat_extra = lfsr_q[2:0];
`else
  assign lat_extra = 3'd0;
`endif

  // cnt holds the WAIT cycles still to spend; the cycle that would decrement
  // it to zero is the one that reads the array and moves to RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_resp = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ram_raddr_valid_icache_i) begin
          if (lat_load == '0) begin
            go_resp = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = lat_load;
          end
        end
      end
      ST_WAIT: begin
        if (!ram_raddr_valid_icache_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(1)) begin
          go_resp = 1'b1;
          state_d = ST_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      mask_q  <= '0;
      omask_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (req_take) begin
        addr_q <= ram_raddr_icache_i;
        mask_q <= ram_rmask_icache_i;
      end
      // Output lane mask is non-zero only for the RESP cycle of an in-range
      // read; this also forces data to zero for errors and after reset.
      omask_q <= (go_resp && rd_in_range) ? rd_mask : 8'h00;
      err_q   <= go_resp && !rd_in_range;
    end
  end

  icache_ram_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we    (preload_we_i && wr_in_range),
    .waddr (wr_off[DEPTH_LOG2+2:3]),
    .wdata (preload_wdata_i),
    .re    (go_resp),
    .raddr (rd_off[DEPTH_LOG2+2:3]),
    .rdata (arr_rdata)
  );

  assign ram_rdata_ready_icache_o = (state_q == ST_RESP);
  assign resp_err_o               = err_q;

  always_comb begin
    ram_rdata_icache_o = '0;
    for (int i = 0; i < 8; i++)
      ram_rdata_icache_o[i*8 +: 8] = omask_q[i] ? arr_rdata[i*8 +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_icache_ram_responder.sv
`timescale 1ns/1ps
module tb_icache_ram_responder;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          DL     = 12;
  localparam int          RD_LAT = 2;
`ifdef ICACHE_RAM_RESP_RAND_LAT_EN
  localparam int          LAT_MAX = RD_LAT + 7;
`else
  localparam int          LAT_MAX = RD_LAT;
`endif
  localparam logic [31:0] SPAN = 32'd8 << DL;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr;
  logic        rvalid;
  logic [7:0]  rmask;
  logic        rdy;
  logic [63:0] rdata;
  logic        err;
  logic        pwe;
  logic [31:0] pwaddr;
  logic [63:0] pwdata;

  always #5 clk = ~clk;

  icache_ram_responder #(.MEM_BASE(BASE), .DEPTH_LOG2(DL), .RD_LAT(RD_LAT)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .ram_raddr_icache_i       (raddr),
    .ram_raddr_valid_icache_i (rvalid),
    .ram_rmask_icache_i       (rmask),
    .ram_rdata_ready_icache_o (rdy),
    .ram_rdata_icache_o       (rdata),
    .resp_err_o               (err),
    .preload_we_i             (pwe),
    .preload_waddr_i          (pwaddr),
    .preload_wdata_i          (pwdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mmem [0:(1<<DL)-1];
  bit          out_pend  = 1'b0;
  bit          resp_seen = 1'b0;
  int          elapsed   = 0;
  logic [31:0] p_addr;
  logic [7:0]  p_mask;
  int          cyc = 0, rsp_count = 0, last_cyc = 0, last_lat = 0;
  logic [63:0] last_data;
  logic        last_err;

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < SPAN;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = (a - BASE) >> 3;
    return int'(o);
  endfunction

  function automatic logic [63:0] exp_data(input logic [31:0] a, input logic [7:0] m);
    logic [63:0] w, r;
    r = '0;
    if (!in_rng(a)) return 64'h0;
    w = mmem[widx(a)];
    for (int i = 0; i < 8; i++) if (m[i]) r[i*8 +: 8] = w[i*8 +: 8];
    return r;
  endfunction

  // Request bookkeeping: a request is outstanding from its acceptance edge
  // until its ready pulse; the cycle of the pulse can never accept.
  always @(posedge clk) begin
    cyc++;
    if (pwe && in_rng(pwaddr)) mmem[widx(pwaddr)] = pwdata;
    if (rst) begin
      out_pend  = 1'b0;
      resp_seen = 1'b0;
    end else if (resp_seen) begin
      resp_seen = 1'b0;
    end else if (out_pend) begin
      if (!rvalid) out_pend = 1'b0;
      else         elapsed++;
    end else if (rvalid) begin
      out_pend = 1'b1;
      elapsed  = 1;
      p_addr   = raddr;
      p_mask   = rmask;
    end
  end

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    bit may, must;
    if (rst) begin
      chk("reset_ready", rdy, 0);
      chk("reset_data", rdata, 0);
      chk("reset_err", err, 0);
    end else begin
      may  = out_pend && elapsed >= RD_LAT;
      must = out_pend && elapsed >= LAT_MAX;
      if (rdy) begin
        chk("ready_allowed", may, 1);
        if (may) begin
          chk("rsp_data", rdata, exp_data(p_addr, p_mask));
          chk("rsp_err", err, !in_rng(p_addr));
          last_data = rdata;
          last_err  = err;
          last_lat  = elapsed;
          last_cyc  = cyc;
          rsp_count++;
          out_pend  = 1'b0;
          resp_seen = 1'b1;
        end
      end else begin
        chk("err_without_ready", err, 0);
        if (must) begin
          chk("ready_by_deadline", rdy, 1);
          out_pend = 1'b0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [63:0] d);
    pwe = 1'b1; pwaddr = a; pwdata = d;
    step;
    pwe = 1'b0;
  endtask

  task automatic wait_rsp(input int n0);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_count > n0) begin ok = 1'b1; break; end
      step;
    end
    chk("response_arrived", ok, 1);
  endtask

  task automatic do_req(input logic [31:0] a, input logic [7:0] m);
    int n0;
    n0 = rsp_count;
    raddr = a; rmask = m; rvalid = 1'b1;
    wait_rsp(n0);
    rvalid = 1'b0;
    step;
  endtask

  function automatic logic [31:0] rand_addr();
    int s, idx;
    s = $urandom_range(0, 15);
    if (s == 0) return BASE + SPAN + 32'($urandom_range(0, 1023) << 3);
    if (s == 1) return BASE - 32'($urandom_range(1, 1024) << 3);
    idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 63) : $urandom_range(4032, 4095);
    return BASE + 32'(idx * 8) + 32'($urandom_range(0, 7));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0, c1, c2;
    logic [63:0] d1, d2;
    logic [31:0] a;

    rst = 1'b1; rvalid = 1'b0; raddr = '0; rmask = '0;
    pwe = 1'b0; pwaddr = '0; pwdata = '0;

    // Preloads while reset is held.
    for (int i = 0; i < 64; i++)     preload(BASE + 32'(i*8), {$urandom, $urandom});
    for (int i = 4032; i < 4096; i++) preload(BASE + 32'(i*8), {$urandom, $urandom});
    preload(BASE + 32'h00, 64'h0000_0000_0000_AAAA);
    preload(BASE + 32'h10, 64'h1122_3344_5566_7788);
    preload(BASE + 32'h20, 64'hA0A1_A2A3_A4A5_A6A7);
    preload(BASE + 32'h28, 64'hB0B1_B2B3_B4B5_B6B7);
    preload(BASE + 32'h40, 64'h0123_4567_89AB_CDEF);
    preload(BASE + SPAN - 8, 64'hFEED_FACE_CAFE_0FFF);
    rst = 1'b0;
    step;

    // Single read.
    do_req(BASE + 32'h10, 8'hFF);
    chk("single_data", last_data, 64'h1122_3344_5566_7788);
    chk("single_err", last_err, 0);
`ifdef ICACHE_RAM_RESP_RAND_LAT_EN
    chk("single_lat_window", (last_lat >= 2 && last_lat <= 9), 1);
`else
    chk("single_lat", last_lat, 2);
`endif

    // Two-beat refill with valid held across beats.
    n0 = rsp_count;
    raddr = BASE + 32'h20; rmask = 8'hFF; rvalid = 1'b1;
    wait_rsp(n0);
    d1 = last_data; c1 = last_cyc;
    raddr = BASE + 32'h28;
    wait_rsp(n0 + 1);
    d2 = last_data; c2 = last_cyc;
    rvalid = 1'b0;
    step;
    chk("beat0_data", d1, 64'hA0A1_A2A3_A4A5_A6A7);
    chk("beat1_data", d2, 64'hB0B1_B2B3_B4B5_B6B7);
`ifdef ICACHE_RAM_RESP_RAND_LAT_EN
    chk("beat_gap_min", (c2 - c1) >= 3, 1);
`else
    chk("beat_gap", c2 - c1, 3);
`endif

    // Masking, ignored low address bits, range errors.
    do_req(BASE + 32'h10, 8'h0F);
    chk("mask_0f", last_data, 64'h0000_0000_5566_7788);
    do_req(BASE + 32'h17, 8'hF0);
    chk("mask_f0_unaligned", last_data, 64'h1122_3344_0000_0000);
    do_req(32'h7FFF_FFF8, 8'hFF);
    chk("below_base_data", last_data, 0);
    chk("below_base_err", last_err, 1);
    do_req(BASE + SPAN - 8, 8'hFF);
    chk("top_word_data", last_data, 64'hFEED_FACE_CAFE_0FFF);
    chk("top_word_err", last_err, 0);
    do_req(BASE + SPAN, 8'hFF);
    chk("past_end_err", last_err, 1);
    chk("past_end_data", last_data, 0);

    // Out-of-range preload must not alias onto word 0.
    preload(BASE + SPAN, 64'hBAD0_BAD0_BAD0_BAD0);
    do_req(BASE, 8'hFF);
    chk("oor_preload_dropped", last_data, 64'h0000_0000_0000_AAAA);

    // Withdrawal in WAIT.
    n0 = rsp_count;
    raddr = BASE + 32'h10; rmask = 8'hFF; rvalid = 1'b1;
    step;
    rvalid = 1'b0;
    repeat (12) step;
    chk("withdraw_no_ready", rsp_count, n0);
    do_req(BASE + 32'h28, 8'hFF);
    chk("after_withdraw", last_data, 64'hB0B1_B2B3_B4B5_B6B7);

    // Reset mid-WAIT.
    raddr = BASE + 32'h20; rmask = 8'hFF; rvalid = 1'b1;
    step;
    rst = 1'b1; rvalid = 1'b0;
    step;
    chk("rst_mid_wait_ready", rdy, 0);
    chk("rst_mid_wait_data", rdata, 0);
    rst = 1'b0;
    step;
    do_req(BASE + 32'h20, 8'hFF);
    chk("array_kept_over_reset", last_data, 64'hA0A1_A2A3_A4A5_A6A7);

    // Write-first collision on the read edge.
    n0 = rsp_count;
    raddr = BASE + 32'h40; rmask = 8'hFF; rvalid = 1'b1;
    step;
    preload(BASE + 32'h40, 64'hDEAD_BEEF_0000_0001);
    wait_rsp(n0);
    rvalid = 1'b0;
    step;
    chk("write_first", last_data, 64'hDEAD_BEEF_0000_0001);

    // Random traffic.
    for (int k = 0; k < 1000; k++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 15) preload(rand_addr() & 32'hFFFF_FFF8, {$urandom, $urandom});
      a = rand_addr();
      if (r >= 90) begin
        n0 = rsp_count;
        raddr = a; rmask = 8'($urandom); rvalid = 1'b1;
        step;
        rvalid = 1'b0;
        repeat (2) step;
        chk("rand_withdraw", rsp_count, n0);
      end else begin
        n0 = rsp_count;
        do_req(a, 8'($urandom));
        chk("rand_one_ready", rsp_count, n0 + 1);
      end
    end

    repeat (3) step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
